// File: rtl/minisys_mem_pkg.sv
// Shared definitions for the Minisys-1A memory stage: access-size encodings, the bus FSM
// states and the bubble values loaded into the EX/MEM and MEM/WB pipeline registers.
package minisys_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] rt_value;
        logic [4:0]  addr;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memsign;
        logic [1:0]  memsize;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        regwrite;
        logic        adel;
        logic        ades;
        logic        bus_err;
    } mem_wb_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_align32.sv
// Combinational little-endian byte-lane steering: store replication, byte enables,
// load extraction with sign/zero extension, and the natural-alignment check.
module mem_align32
    import minisys_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    input  logic        load_sign,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[8*addr_lo +: 8];
    assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{load_sign & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{load_sign & lane_h[15]}}, lane_h};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage32.sv
// Minisys-1A memory stage: EX/MEM register, single-outstanding request/ack data bus and
// MEM/WB register. Optional request timeout is built when MEM_TIMEOUT_EN is defined.
module mem_stage32
    import minisys_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] rt_value,
    input  logic [4:0]  address,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemSign,
    input  logic [1:0]  MemSize,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [31:0] EX_MEM_ALU_result,
    output logic [31:0] WB_data,
    output logic [4:0]  wb_addr,
    output logic        wb_regwrite,
    output logic        adel,
    output logic        ades,
    output logic        bus_err
);

    ex_mem_t    ex_mem_q, ex_mem_d;
    mem_wb_t    mem_wb_q, mem_wb_d;
    mem_state_e state_q, state_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misaligned;
    logic        is_mem;
    logic        exc_misalign;
    logic        req;
    logic        timeout;

    mem_align32 u_align (
        .addr_lo    (ex_mem_q.alu_result[1:0]),
        .size       (ex_mem_q.memsize),
        .store_data (ex_mem_q.rt_value),
        .rdata      (mem_rdata),
        .load_sign  (ex_mem_q.memsign),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_misaligned)
    );

    assign is_mem       = ex_mem_q.valid & (ex_mem_q.memread | ex_mem_q.memwrite);
    assign exc_misalign = is_mem & al_misaligned;
    // In WAIT the EX/MEM register is frozen, so the request and its fields stay stable.
    assign req          = (state_q == StWait) | (is_mem & ~al_misaligned);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Timeout fires in the last permitted WAIT cycle; an ack in that cycle still wins.
    assign timeout = (state_q == StWait) & ~mem_ack &
                     (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    assign mem_stall = req & ~mem_ack & ~timeout;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req && !mem_ack)       state_d = StWait;
            StWait: if (mem_ack || timeout)    state_d = StIdle;
            default:                           state_d = StIdle;
        endcase
    end

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!mem_stall) begin
            if (flush) begin
                ex_mem_d = EX_MEM_BUBBLE;
            end else begin
                ex_mem_d.valid      = ex_valid;
                ex_mem_d.alu_result = ALU_Result;
                ex_mem_d.rt_value   = rt_value;
                ex_mem_d.addr       = address;
                ex_mem_d.regwrite   = RegWrite;
                ex_mem_d.memread    = MemRead;
                ex_mem_d.memwrite   = MemWrite;
                ex_mem_d.memsign    = MemSign;
                ex_mem_d.memsize    = MemSize;
            end
        end
    end

    always_comb begin
        mem_wb_d = MEM_WB_BUBBLE;
        if (!mem_stall) begin
            mem_wb_d.data     = (ex_mem_q.memread && !exc_misalign) ? al_load
                                                                    : ex_mem_q.alu_result;
            mem_wb_d.addr     = ex_mem_q.addr;
            mem_wb_d.regwrite = ex_mem_q.valid & ex_mem_q.regwrite & ~ex_mem_q.memwrite &
                                ~exc_misalign & ~timeout;
            mem_wb_d.adel     = exc_misalign & ex_mem_q.memread;
            mem_wb_d.ades     = exc_misalign & ex_mem_q.memwrite;
            mem_wb_d.bus_err  = timeout;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ex_mem_q <= EX_MEM_BUBBLE;
            mem_wb_q <= MEM_WB_BUBBLE;
        end else begin
            state_q  <= state_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_req           = req;
    assign mem_we            = req & ex_mem_q.memwrite;
    assign mem_addr          = req ? {ex_mem_q.alu_result[31:2], 2'b00} : 32'h0;
    assign mem_be            = req ? al_be : 4'b0000;
    assign mem_wdata         = (req && ex_mem_q.memwrite) ? al_wdata : 32'h0;
    assign EX_MEM_ALU_result = ex_mem_q.alu_result;
    assign WB_data           = mem_wb_q.data;
    assign wb_addr           = mem_wb_q.addr;
    assign wb_regwrite       = mem_wb_q.regwrite;
    assign adel              = mem_wb_q.adel;
    assign ades              = mem_wb_q.ades;
    assign bus_err           = mem_wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage32.sv
// Self-checking bench for mem_stage32: table of single-cycle accesses plus hand sequences
// for delayed ack, flush, asynchronous reset mid-WAIT and (with MEM_TIMEOUT_EN) timeout.
module tb_mem_stage32;

    logic        clock;
    logic        reset_n;
    logic        ex_valid;
    logic [31:0] ALU_Result;
    logic [31:0] rt_value;
    logic [4:0]  address;
    logic        RegWrite, MemRead, MemWrite, MemSign;
    logic [1:0]  MemSize;
    logic        flush;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [31:0] EX_MEM_ALU_result, WB_data;
    logic [4:0]  wb_addr;
    logic        wb_regwrite, adel, ades, bus_err;

    int n_pass  = 0;
    int n_total = 0;
    int step    = 0;

    mem_stage32 #(.TIMEOUT_CYCLES(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ex_valid          (ex_valid),
        .ALU_Result        (ALU_Result),
        .rt_value          (rt_value),
        .address           (address),
        .RegWrite          (RegWrite),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .MemSign           (MemSign),
        .MemSize           (MemSize),
        .flush             (flush),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .mem_stall         (mem_stall),
        .EX_MEM_ALU_result (EX_MEM_ALU_result),
        .WB_data           (WB_data),
        .wb_addr           (wb_addr),
        .wb_regwrite       (wb_regwrite),
        .adel              (adel),
        .ades              (ades),
        .bus_err           (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        mr, mw, ms, rw;
        logic [1:0]  sz;
        logic [31:0] alu, rt, rdata;
        logic [4:0]  rd;
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_wb;
        logic        exp_rw, exp_adel, exp_ades;
    } vec_t;

    function automatic vec_t mk(input logic mr, mw, ms, rw, input logic [1:0] sz,
                                input logic [31:0] alu, rt, rdata, input logic [4:0] rd,
                                input logic er, input logic [3:0] ebe,
                                input logic [31:0] ewd, ewb, input logic erw, ead, eas);
        vec_t v;
        v.mr = mr; v.mw = mw; v.ms = ms; v.rw = rw; v.sz = sz;
        v.alu = alu; v.rt = rt; v.rdata = rdata; v.rd = rd;
        v.exp_req = er; v.exp_be = ebe; v.exp_wdata = ewd; v.exp_wb = ewb;
        v.exp_rw = erw; v.exp_adel = ead; v.exp_ades = eas;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, rt, input logic [4:0] rd,
                         input logic rw, mr, mw, ms, input logic [1:0] sz, input logic fl);
        ex_valid = v; ALU_Result = alu; rt_value = rt; address = rd;
        RegWrite = rw; MemRead = mr; MemWrite = mw; MemSign = ms; MemSize = sz; flush = fl;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = v.exp_req ? {v.alu[31:2], 2'b00} : 32'h0;
        @(negedge clock);
        drive(1'b1, v.alu, v.rt, v.rd, v.rw, v.mr, v.mw, v.ms, v.sz, 1'b0);
        @(negedge clock);
        bubble();
        mem_ack   = 1'b1;    // also asserted for non-requests: must be ignored
        mem_rdata = v.rdata;
        #1;
        chk("ex_mem_alu", EX_MEM_ALU_result, v.alu);
        chk("mem_req", {31'h0, mem_req}, {31'h0, v.exp_req});
        chk("mem_we", {31'h0, mem_we}, {31'h0, v.exp_req & v.mw});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'h0, mem_be}, {28'h0, v.exp_be});
        chk("mem_wdata", mem_wdata, v.exp_wdata);
        chk("mem_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        chk("wb_data", WB_data, v.exp_wb);
        chk("wb_addr", {27'h0, wb_addr}, {27'h0, v.rd});
        chk("wb_regwrite", {31'h0, wb_regwrite}, {31'h0, v.exp_rw});
        chk("adel", {31'h0, adel}, {31'h0, v.exp_adel});
        chk("ades", {31'h0, ades}, {31'h0, v.exp_ades});
        @(posedge clock);
        #1;
        chk("pulse_end", {29'h0, adel, ades, wb_regwrite}, 32'h0);
    endtask

    vec_t vecs[14];

    initial begin
        int n_stall;
        int n_req;
        int n_berr;

        vecs[0]  = mk(1,0,0,1, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5,
                      1, 4'b1111, 32'h0, 32'hDEADBEEF, 1, 0, 0);
        vecs[1]  = mk(1,0,1,1, 2'b00, 32'h103, 32'h0, 32'h80123456, 5'd6,
                      1, 4'b1000, 32'h0, 32'hFFFFFF80, 1, 0, 0);
        vecs[2]  = mk(1,0,0,1, 2'b00, 32'h103, 32'h0, 32'h80123456, 5'd7,
                      1, 4'b1000, 32'h0, 32'h00000080, 1, 0, 0);
        vecs[3]  = mk(1,0,1,1, 2'b01, 32'h102, 32'h0, 32'h80017FFF, 5'd8,
                      1, 4'b1100, 32'h0, 32'hFFFF8001, 1, 0, 0);
        vecs[4]  = mk(1,0,0,1, 2'b01, 32'h100, 32'h0, 32'h8001F00D, 5'd9,
                      1, 4'b0011, 32'h0, 32'h0000F00D, 1, 0, 0);
        vecs[5]  = mk(1,0,1,1, 2'b00, 32'h101, 32'h0, 32'h00007F00, 5'd10,
                      1, 4'b0010, 32'h0, 32'h0000007F, 1, 0, 0);
        vecs[6]  = mk(0,1,0,1, 2'b00, 32'h102, 32'hFFFFFFA5, 32'h12345678, 5'd11,
                      1, 4'b0100, 32'hA5A5A5A5, 32'h102, 0, 0, 0);
        vecs[7]  = mk(0,1,0,0, 2'b10, 32'h200, 32'h11223344, 32'h0, 5'd1,
                      1, 4'b1111, 32'h11223344, 32'h200, 0, 0, 0);
        vecs[8]  = mk(0,0,0,1, 2'b10, 32'hCAFEF00D, 32'h0, 32'h0, 5'd12,
                      0, 4'b0000, 32'h0, 32'hCAFEF00D, 1, 0, 0);
        vecs[9]  = mk(1,0,1,1, 2'b10, 32'h101, 32'h0, 32'h55555555, 5'd13,
                      0, 4'b0000, 32'h0, 32'h101, 0, 1, 0);
        vecs[10] = mk(0,1,0,0, 2'b01, 32'h103, 32'hBEEF, 32'h0, 5'd2,
                      0, 4'b0000, 32'h0, 32'h103, 0, 0, 1);
        vecs[11] = mk(0,1,0,0, 2'b10, 32'h202, 32'h1, 32'h0, 5'd3,
                      0, 4'b0000, 32'h0, 32'h202, 0, 0, 1);
        vecs[12] = mk(1,0,1,1, 2'b01, 32'h101, 32'h0, 32'h0, 5'd14,
                      0, 4'b0000, 32'h0, 32'h101, 0, 1, 0);
        vecs[13] = mk(1,0,0,0, 2'b10, 32'h7FC, 32'h0, 32'h0BADF00D, 5'd15,
                      1, 4'b1111, 32'h0, 32'h0BADF00D, 0, 0, 0);

        reset_n   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        bubble();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_bus_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_ex_mem", EX_MEM_ALU_result, 32'h0);
        chk("rst_wb_data", WB_data, 32'h0);
        chk("rst_wb_ctl", {23'h0, wb_addr, wb_regwrite, adel, ades, bus_err}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step = i + 1;
            run_vec(vecs[i]);
        end

        // sh at 0x102 with ack three cycles late; flush plus a new op held during the stall
        step = 100;
        @(negedge clock);
        drive(1'b1, 32'h102, 32'h1234ABCD, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
        @(negedge clock);
        drive(1'b1, 32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        mem_ack = 1'b0;
        n_stall = 0;
        for (int c = 0; c < 10; c++) begin
            mem_ack = (c >= 3);
            #1;
            chk("dly_req", {31'h0, mem_req}, 32'h1);
            chk("dly_be", {28'h0, mem_be}, 32'hC);
            chk("dly_wdata", mem_wdata, 32'hABCDABCD);
            chk("dly_addr", mem_addr, 32'h100);
            chk("dly_ex_mem", EX_MEM_ALU_result, 32'h102);
            if (!mem_stall) break;
            n_stall++;
            @(posedge clock);
            #1;
            chk("dly_wb_bubble", {31'h0, wb_regwrite}, 32'h0);
            @(negedge clock);
        end
        chk("dly_stall_cycles", n_stall, 3);
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
        chk("dly_wb_data", WB_data, 32'h102);
        chk("dly_wb_ctl", {30'h0, wb_regwrite, ades}, 32'h0);
        chk("dly_flushed", EX_MEM_ALU_result, 32'h0);
        @(negedge clock);
        bubble();
        @(posedge clock);
        #1;
        chk("dly_flushed_wb", WB_data, 32'h0);

        // flush without a stall captures a bubble
        step = 200;
        @(negedge clock);
        drive(1'b1, 32'h77, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        @(negedge clock);
        bubble();
        #1;
        chk("flush_ex_mem", EX_MEM_ALU_result, 32'h0);
        @(posedge clock);
        #1;
        chk("flush_wb", {31'h0, wb_regwrite}, 32'h0);

        // asynchronous reset in the middle of WAIT
        step = 300;
        @(negedge clock);
        drive(1'b1, 32'h300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        @(negedge clock);
        bubble();
        mem_ack = 1'b0;
        #1;
        chk("rw_req", {31'h0, mem_req}, 32'h1);
        @(negedge clock);
        #1;
        chk("rw_wait_stall", {31'h0, mem_stall}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rw_req_dropped", {30'h0, mem_req, mem_stall}, 32'h0);
        chk("rw_ex_mem", EX_MEM_ALU_result, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        chk("rw_discarded", {30'h0, mem_req, wb_regwrite}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // never-acked lw: 1 IDLE + 4 WAIT request cycles, the last one times out
        step = 400;
        @(negedge clock);
        drive(1'b1, 32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        @(negedge clock);
        bubble();
        mem_ack = 1'b0;
        n_req   = 0;
        n_stall = 0;
        n_berr  = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!mem_req) break;
            n_req++;
            if (mem_stall) n_stall++;
            @(posedge clock);
            #1;
            if (bus_err) begin
                n_berr++;
                chk("to_wb_regwrite", {31'h0, wb_regwrite}, 32'h0);
            end
            @(negedge clock);
        end
        chk("to_req_cycles", n_req, 5);
        chk("to_stall_cycles", n_stall, 4);
        chk("to_bus_err_pulses", n_berr, 1);
        @(posedge clock);
        #1;
        chk("to_bus_err_clear", {31'h0, bus_err}, 32'h0);
`else
        chk("bus_err_tied", {31'h0, bus_err}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
